// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential 3-digit BCD to binary converter (reverse double-dabble)
//
// Converts a hundreds/tens/ones BCD value into an OUT_WIDTH-bit binary value,
// one shift-and-correct step per clock.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   start  in   conversion request, sampled only in IDLE
//   bcd2   in   hundreds digit
//   bcd1   in   tens digit
//   bcd0   in   ones digit
//   busy   out  conversion in progress (SHIFT state)
//   done   out  one-cycle pulse when bin/ovf/derr are updated
//   bin    out  converted value, held until the next completion
//   ovf    out  result exceeded 2^OUT_WIDTH-1, bin saturated
//   derr   out  a digit was >9, bin forced to 0

module bcd_to_bin_seq #(
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           bcd2,
  input  logic [3:0]           bcd1,
  input  logic [3:0]           bcd0,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] bin,
  output logic                 ovf,
  output logic                 derr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Largest value representable on bin, widened to compare against the
  // 10-bit accumulator without truncation.
  localparam logic [10:0] MAX_VAL = 11'((1 << OUT_WIDTH) - 1);

  state_t               state_q;
  logic [11:0]          bcd_q;
  logic [11:0]          bcd_d;
  logic [11:0]          bcd_sh;
  logic [9:0]           acc_q;
  logic [9:0]           acc_d;
  logic [3:0]           cnt_q;
  logic [OUT_WIDTH-1:0] bin_q;
  logic                 ovf_q;
  logic                 derr_q;
  logic                 done_q;
  logic                 digit_err;
  logic                 res_ovf;

  // One reverse double-dabble step: shift {bcd,acc} right by one, then pull
  // 3 out of every digit that landed at 8 or above (bit 3 set), which undoes
  // the weight-16-vs-10 error of the bit that crossed a digit boundary.
  always_comb begin
    bcd_sh = {1'b0, bcd_q[11:1]};
    acc_d  = {bcd_q[0], acc_q[9:1]};
    bcd_d  = bcd_sh;
    for (int i = 0; i < 3; i++) begin
      if (bcd_sh[4*i+3]) begin
        bcd_d[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
      end
    end
  end

  assign digit_err = (bcd2 > 4'd9) || (bcd1 > 4'd9) || (bcd0 > 4'd9);
  assign res_ovf   = ({1'b0, acc_d} > MAX_VAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      derr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            bcd_q <= {bcd2, bcd1, bcd0};
            acc_q <= '0;
            cnt_q <= '0;
            if (digit_err) begin
              // Bad digit: report immediately, no shifting.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              derr_q  <= 1'b1;
              ovf_q   <= 1'b0;
              bin_q   <= '0;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end

        ST_SHIFT: begin
          bcd_q <= bcd_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd9) begin
            // Tenth shift: acc_d already holds the final binary value.
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            derr_q  <= 1'b0;
            ovf_q   <= res_ovf;
            bin_q   <= res_ovf ? '1 : acc_d[OUT_WIDTH-1:0];
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;
  assign bin  = bin_q;
  assign ovf  = ovf_q;
  assign derr = derr_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - directed self-checking bench for bcd_to_bin_seq

module tb_bcd_to_bin_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] bcd2, bcd1, bcd0;

  logic       busy8, done8, ovf8, derr8;
  logic [7:0] bin8;
  logic       busy10, done10, ovf10, derr10;
  logic [9:0] bin10;

  int n_vec = 0;
  int n_err = 0;

  bcd_to_bin_seq #(.OUT_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start),
    .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .busy(busy8), .done(done8), .bin(bin8), .ovf(ovf8), .derr(derr8)
  );

  bcd_to_bin_seq #(.OUT_WIDTH(10)) dut10 (
    .clk(clk), .reset(reset), .start(start),
    .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .busy(busy10), .done(done10), .bin(bin10), .ovf(ovf10), .derr(derr10)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one conversion and wait for done. cycles = edges from the start
  // edge to the sample that shows done; busy_cnt = samples with busy high;
  // both_hi set if busy and done were ever seen together.
  task automatic run_conv(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0,
                          output int cycles, output int busy_cnt, output bit both_hi);
    bcd2 = d2; bcd1 = d1; bcd0 = d0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 1;
    busy_cnt = 0;
    both_hi = 1'b0;
    while (!done8 && cycles < 30) begin
      if (busy8) busy_cnt++;
      if (busy8 && done8) both_hi = 1'b1;
      tick();
      cycles++;
    end
    if (busy8 && done8) both_hi = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0;
    tick(); tick();
    n_vec++;
    if ({busy8, done8, bin8, ovf8, derr8} !== 12'h000) begin
      $display("FAIL reset_outputs8 got busy=%b done=%b bin=%h ovf=%b derr=%b want all 0",
               busy8, done8, bin8, ovf8, derr8);
      n_err++;
    end
    n_vec++;
    if ({busy10, done10, bin10, ovf10, derr10} !== 14'h0000) begin
      $display("FAIL reset_outputs10 got busy=%b done=%b bin=%h ovf=%b derr=%b want all 0",
               busy10, done10, bin10, ovf10, derr10);
      n_err++;
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_255();
    int cyc, bcnt; bit both;
    run_conv(4'd2, 4'd5, 4'd5, cyc, bcnt, both);
    n_vec++;
    if (cyc !== 11) begin $display("FAIL lat_255 got %0d cycles want 11", cyc); n_err++; end
    n_vec++;
    if (bcnt !== 10) begin $display("FAIL busy_255 got %0d busy cycles want 10", bcnt); n_err++; end
    n_vec++;
    if (both !== 1'b0) begin $display("FAIL busy_done_overlap got 1 want 0"); n_err++; end
    n_vec++;
    if ({bin8, ovf8, derr8} !== {8'hFF, 1'b0, 1'b0}) begin
      $display("FAIL res_255_w8 got bin=%h ovf=%b derr=%b want bin=ff ovf=0 derr=0", bin8, ovf8, derr8);
      n_err++;
    end
    n_vec++;
    if ({bin10, ovf10} !== {10'h0FF, 1'b0}) begin
      $display("FAIL res_255_w10 got bin=%h ovf=%b want bin=0ff ovf=0", bin10, ovf10);
      n_err++;
    end
    tick();
    n_vec++;
    if (done8 !== 1'b0) begin $display("FAIL done_one_cycle got 1 want 0"); n_err++; end
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt, gap; bit both;
    run_conv(4'd1, 4'd2, 4'd7, cyc, bcnt, both);
    n_vec++;
    if (bin8 !== 8'h7F) begin $display("FAIL res_127 got %h want 7f", bin8); n_err++; end
    // start held through the DONE edge (ignored) and the first IDLE edge (taken)
    bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0;
    start = 1'b1;
    tick();
    n_vec++;
    if ({busy8, done8} !== 2'b00) begin
      $display("FAIL start_in_done got busy=%b done=%b want 0 0", busy8, done8);
      n_err++;
    end
    tick();
    start = 1'b0;
    n_vec++;
    if (busy8 !== 1'b1) begin $display("FAIL b2b_accept got busy=%b want 1", busy8); n_err++; end
    gap = 2;
    while (!done8 && gap < 40) begin tick(); gap++; end
    n_vec++;
    if (gap !== 12) begin $display("FAIL b2b_spacing got %0d want 12", gap); n_err++; end
    n_vec++;
    if ({bin8, ovf8, derr8} !== 10'h000) begin
      $display("FAIL res_000 got bin=%h ovf=%b derr=%b want 00 0 0", bin8, ovf8, derr8);
      n_err++;
    end
    tick();
  endtask

  task automatic test_overflow();
    int cyc, bcnt; bit both;
    run_conv(4'd2, 4'd5, 4'd6, cyc, bcnt, both);
    n_vec++;
    if ({bin8, ovf8} !== {8'hFF, 1'b1}) begin
      $display("FAIL ovf_256_w8 got bin=%h ovf=%b want ff 1", bin8, ovf8);
      n_err++;
    end
    n_vec++;
    if ({bin10, ovf10} !== {10'h100, 1'b0}) begin
      $display("FAIL res_256_w10 got bin=%h ovf=%b want 100 0", bin10, ovf10);
      n_err++;
    end
    tick();
    run_conv(4'd9, 4'd9, 4'd9, cyc, bcnt, both);
    n_vec++;
    if ({bin8, ovf8, derr8} !== {8'hFF, 1'b1, 1'b0}) begin
      $display("FAIL ovf_999_w8 got bin=%h ovf=%b derr=%b want ff 1 0", bin8, ovf8, derr8);
      n_err++;
    end
    n_vec++;
    if ({bin10, ovf10} !== {10'h3E7, 1'b0}) begin
      $display("FAIL res_999_w10 got bin=%h ovf=%b want 3e7 0", bin10, ovf10);
      n_err++;
    end
    tick();
  endtask

  task automatic test_digit_error();
    int cyc, bcnt; bit both;
    run_conv(4'd1, 4'hA, 4'd3, cyc, bcnt, both);
    n_vec++;
    if (cyc !== 1) begin $display("FAIL derr_latency got %0d want 1", cyc); n_err++; end
    n_vec++;
    if (bcnt !== 0) begin $display("FAIL derr_busy got %0d busy cycles want 0", bcnt); n_err++; end
    n_vec++;
    if ({bin8, ovf8, derr8} !== {8'h00, 1'b0, 1'b1}) begin
      $display("FAIL derr_w8 got bin=%h ovf=%b derr=%b want 00 0 1", bin8, ovf8, derr8);
      n_err++;
    end
    n_vec++;
    if ({bin10, ovf10, derr10} !== {10'h000, 1'b0, 1'b1}) begin
      $display("FAIL derr_w10 got bin=%h ovf=%b derr=%b want 000 0 1", bin10, ovf10, derr10);
      n_err++;
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int ndone;
    logic [7:0] last_bin;
    ndone = 0;
    last_bin = 8'h00;
    bcd2 = 4'd1; bcd1 = 4'd0; bcd0 = 4'd0;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 18; k++) begin
      start = (k == 3 || k == 11);
      if (k == 2) begin bcd2 = 4'd9; bcd1 = 4'd8; bcd0 = 4'd7; end
      tick();
      if (done8) begin ndone++; last_bin = bin8; end
    end
    start = 1'b0;
    n_vec++;
    if (ndone !== 1) begin $display("FAIL ignore_done_count got %0d want 1", ndone); n_err++; end
    n_vec++;
    if (last_bin !== 8'h64) begin $display("FAIL ignore_bin got %h want 64", last_bin); n_err++; end
  endtask

  task automatic test_reset_mid();
    int ndone, cyc, bcnt; bit both;
    ndone = 0;
    bcd2 = 4'd0; bcd1 = 4'd4; bcd0 = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 5; k++) begin tick(); if (done8) ndone++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if ({busy8, done8, bin8, ovf8, derr8} !== 12'h000) begin
      $display("FAIL reset_mid got busy=%b done=%b bin=%h ovf=%b derr=%b want all 0",
               busy8, done8, bin8, ovf8, derr8);
      n_err++;
    end
    for (int k = 0; k < 14; k++) begin tick(); if (done8 || busy8) ndone++; end
    n_vec++;
    if (ndone !== 0) begin $display("FAIL reset_mid_activity got %0d want 0", ndone); n_err++; end
    run_conv(4'd0, 4'd4, 4'd2, cyc, bcnt, both);
    n_vec++;
    if ({bin8, ovf8, derr8} !== {8'h2A, 1'b0, 1'b0}) begin
      $display("FAIL res_042 got bin=%h ovf=%b derr=%b want 2a 0 0", bin8, ovf8, derr8);
      n_err++;
    end
    n_vec++;
    if (cyc !== 11) begin $display("FAIL lat_042 got %0d want 11", cyc); n_err++; end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_255();
    test_back_to_back();
    test_overflow();
    test_digit_error();
    test_ignore_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential 3-digit BCD-to-binary converter. It is the inverse of the display path's binary-to-BCD decoder.
- Converts a hundreds/tens/ones BCD value entered on the switches into an 8-bit binary operand for the register add/sub datapath.
- Uses reverse double-dabble: one shift-and-correct per clock, start/busy/done handshake.
- Flags out-of-range results (>255) and illegal BCD digits (>9).

Parameters:
- OUT_WIDTH, 8, width of the bin output. Legal range 8..10. The internal accumulator is always 10 bits (covers 999).

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request conversion; sampled only in IDLE
- bcd2  input  4  hundreds digit
- bcd1  input  4  tens digit
- bcd0  input  4  ones digit
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when bin/ovf/derr are updated
- bin  output  OUT_WIDTH  converted value, held until the next completion
- ovf  output  1  value exceeded 2^OUT_WIDTH-1; bin saturated
- derr  output  1  a digit was >9; bin forced to 0

Behaviour:
- Reset:
  - Synchronous, active-high, one clock, single clk domain. Overrides everything, including mid-conversion.
  - State to IDLE; iteration counter 0; BCD and accumulator registers 0.
  - busy=0, done=0, bin=0, ovf=0, derr=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0.
  - On an edge N with start=1, latch {bcd2,bcd1,bcd0} into the 12-bit BCD register and clear the 10-bit accumulator.
  - If any digit >9: go to DONE; set derr=1, bin=0, ovf=0. No SHIFT cycles.
  - Otherwise go to SHIFT with counter=0.
- SHIFT:
  - busy=1.
  - Each edge: shift the 22-bit {bcd,acc} right by 1 (BCD LSB enters acc MSB).
  - Then for each 4-bit BCD digit that is >=8, subtract 3 from that digit.
  - Both steps happen in one cycle; counter increments.
  - Runs exactly 10 iterations, on edges N+1..N+10.
- On edge N+10 (last shift), load the outputs and go to DONE:
  - ovf = (result > 2^OUT_WIDTH-1).
  - bin = ovf ? all ones : result[OUT_WIDTH-1:0].
  - derr=0.
  - The result is the accumulator value after the 10th shift.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Unconditionally returns to IDLE on the next edge.
  - start is not accepted in DONE; it is accepted again from the next IDLE cycle.
- Latency:
  - Valid digits: start edge N, done high in the cycle after edge N+10 (11 cycles). Back-to-back issue interval is 12 cycles.
  - Digit error: done high in the cycle after edge N.
- Inputs bcd2..0 are sampled only at the start edge; later changes have no effect on a conversion in flight.
- start while busy or in DONE is ignored. It is not queued.
- bin/ovf/derr change only at the update edge (the edge that enters DONE). They hold between conversions and are never 'X' after reset.
- done is a registered output. busy is derived from state (SHIFT only). done and busy are never both high.
- ovf and derr are never both high.
- With OUT_WIDTH=10, ovf is never set (999 < 1024).

Test Plan:
- Reset, then start with digits 2,5,5 -> busy high 10 cycles; done pulse in cycle 11 after the start edge; bin=8'hFF, ovf=0, derr=0.
- Digits 1,2,7, then digits 0,0,0 back-to-back (second start the first cycle IDLE is re-entered) -> bin=8'h7F, then bin=8'h00; 12-cycle spacing between done pulses.
- Digits 2,5,6 and digits 9,9,9 -> bin=8'hFF, ovf=1 both times. Repeat 9,9,9 with OUT_WIDTH=10 -> bin=10'h3E7, ovf=0.
- Digits 1,10,3 (bcd1=4'hA) -> done in the cycle after the start edge; derr=1, bin=0, ovf=0; busy never asserted.
- Start with 1,0,0, pulse start again at cycles 3 and 11, and change bcd inputs mid-conversion -> a single done; bin=8'h64.
- Start with 0,4,2, assert reset at cycle 5 -> next cycle all outputs 0, state IDLE, no done pulse. A fresh start then yields bin=8'h2A.
